// File: rtl/pixel_top_pkg.sv
// Shared types and constants for the image-sensor model.
package pixel_top_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    localparam int ADC_W    = 8;
    localparam int ACC_W    = 16;
    localparam int CONV_LEN = 256;
    localparam int CNT_W    = 16;

endpackage

// File: rtl/pixel_top_if.sv
// Readout bus of the sensor: sequencer state plus the serial pixel stream.
interface pixel_top_if #(
    parameter int NPIX = 4
);
    import pixel_top_pkg::*;

    localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    logic [2:0]        state;
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic [ADC_W-1:0]  pix_data;

    modport master (output state, output pix_valid, output pix_addr, output pix_data);
    modport slave  (input  state, input  pix_valid, input  pix_addr, input  pix_data);

endinterface

// File: rtl/pixel_sensor.sv
// One pixel: saturating light integrator plus single-slope ADC latch.
module pixel_sensor
    import pixel_top_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             erase,
    input  logic             expose,
    input  logic             convert,
    input  logic [ADC_W-1:0] ramp,
    input  logic [ACC_W-1:0] rate,
    output logic [ADC_W-1:0] mem
);

    logic [ACC_W-1:0] r_acc;
    logic [ADC_W-1:0] r_mem;
    logic             r_latched;
    logic [ACC_W:0]   w_sum;
    logic [ADC_W-1:0] w_value;

    assign w_sum   = {1'b0, r_acc} + {1'b0, rate};
    assign w_value = r_acc[ACC_W-1:ACC_W-ADC_W];

    // Integrate during exposure, capture the ramp once it reaches the pixel value.
    always_ff @(posedge clk) begin
        if (reset || erase) begin
            r_acc     <= '0;
            r_mem     <= '0;
            r_latched <= 1'b0;
        end else begin
            if (expose) begin
                r_acc <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
            end
            if (convert && !r_latched && (ramp >= w_value)) begin
                r_mem     <= ramp;
                r_latched <= 1'b1;
            end
        end
    end

    assign mem = r_mem;

endmodule

// File: rtl/pixel_top.sv
// Self-running sensor top: sequencer FSM, ramp generator, pixel array, readout mux.
module pixel_top
    import pixel_top_pkg::*;
#(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int RATE_STEP = 16,
    parameter int T_ERASE   = 5,
    parameter int T_EXPOSE  = 255
) (
    input  logic       clk,
    input  logic       reset,
    pixel_top_if.master o_pix
);

    localparam int NPIX   = ROWS * COLS;
    localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_dur;
    logic              w_last;
    logic              w_erase;
    logic              w_expose;
    logic              w_convert;
    logic [ADC_W-1:0]  w_ramp;
    logic [ADC_W-1:0]  w_mem [NPIX];

    // Dwell time of the current state.
    always_comb begin
        w_dur = CNT_W'(1);
        case (r_state)
            ST_IDLE:    w_dur = CNT_W'(1);
            ST_ERASE:   w_dur = CNT_W'(T_ERASE);
            ST_EXPOSE:  w_dur = CNT_W'(T_EXPOSE);
            ST_CONVERT: w_dur = CNT_W'(CONV_LEN);
            ST_READ:    w_dur = CNT_W'(NPIX);
            default:    w_dur = CNT_W'(1);
        endcase
    end

    assign w_last = (r_cnt == w_dur - CNT_W'(1));

    // Next-state logic: fixed loop, advancing when the dwell time expires.
    always_comb begin
        w_state_nxt = r_state;
        if (w_last) begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_ERASE;
                ST_ERASE:   w_state_nxt = ST_EXPOSE;
                ST_EXPOSE:  w_state_nxt = ST_CONVERT;
                ST_CONVERT: w_state_nxt = ST_READ;
                ST_READ:    w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register and per-state cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign w_erase   = (r_state == ST_ERASE);
    assign w_expose  = (r_state == ST_EXPOSE);
    assign w_convert = (r_state == ST_CONVERT);
    assign w_ramp    = r_cnt[ADC_W-1:0];

    for (genvar i = 0; i < NPIX; i++) begin : g_pix
        pixel_sensor u_px (
            .clk     (clk),
            .reset   (reset),
            .erase   (w_erase),
            .expose  (w_expose),
            .convert (w_convert),
            .ramp    (w_ramp),
            .rate    (ACC_W'((i + 1) * RATE_STEP)),
            .mem     (w_mem[i])
        );
    end

    // Readout decoded straight from registered state, counter and pixel memories.
    always_comb begin
        o_pix.state     = r_state;
        o_pix.pix_valid = 1'b0;
        o_pix.pix_addr  = '0;
        o_pix.pix_data  = '0;
        if (r_state == ST_READ) begin
            o_pix.pix_valid = 1'b1;
            o_pix.pix_addr  = r_cnt[ADDR_W-1:0];
            o_pix.pix_data  = w_mem[r_cnt[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_pixel_top.sv
// Directed bench for pixel_top: default rates and a saturating-rate instance side by side.
module tb_pixel_top;
    import pixel_top_pkg::*;

    localparam int unsigned FRAME = 521;

    logic clk;
    logic reset;

    pixel_top_if #(.NPIX(4)) if_def ();
    pixel_top_if #(.NPIX(4)) if_sat ();

    pixel_top dut (
        .clk   (clk),
        .reset (reset),
        .o_pix (if_def)
    );

    pixel_top #(.RATE_STEP(128)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .o_pix (if_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned n_valid;
    int unsigned n_bursts;
    logic        prev_valid;

    logic [7:0] exp_def [4];
    logic [7:0] exp_sat [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state at frame position p (p=0 is the IDLE cycle).
    function automatic logic [2:0] exp_state(input int unsigned p);
        if (p == 0)        return 3'd0;
        else if (p <= 5)   return 3'd1;
        else if (p <= 260) return 3'd2;
        else if (p <= 516) return 3'd3;
        else               return 3'd4;
    endfunction

    // Run n cycles after a reset release, checking every cycle against the frame model.
    task automatic run(input int unsigned n);
        int unsigned p;
        logic [2:0]  es;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [31:0] es2;
        for (int unsigned c = 1; c <= n; c++) begin
            tick();
            p  = c % FRAME;
            es = exp_state(p);
            ev = (es == 3'd4);
            ea = ev ? 32'(p - 517) : 32'd0;
            ed = ev ? 32'(exp_def[p - 517]) : 32'd0;
            es2 = ev ? 32'(exp_sat[p - 517]) : 32'd0;
            chk("state",     32'(if_def.state),     32'(es));
            chk("valid",     32'(if_def.pix_valid), 32'(ev));
            chk("addr",      32'(if_def.pix_addr),  ea);
            chk("data",      32'(if_def.pix_data),  ed);
            chk("sat_state", 32'(if_sat.state),     32'(es));
            chk("sat_valid", 32'(if_sat.pix_valid), 32'(ev));
            chk("sat_data",  32'(if_sat.pix_data),  es2);
            if (if_def.pix_valid) n_valid++;
            if (if_def.pix_valid && !prev_valid) n_bursts++;
            prev_valid = if_def.pix_valid;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        n_valid    = 0;
        n_bursts   = 0;
        prev_valid = 1'b0;
        exp_def[0] = 8'd15;  exp_def[1] = 8'd31;  exp_def[2] = 8'd47;  exp_def[3] = 8'd63;
        exp_sat[0] = 8'd127; exp_sat[1] = 8'd255; exp_sat[2] = 8'd255; exp_sat[3] = 8'd255;

        // Reset held for three cycles.
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_state", 32'(if_def.state),     32'd0);
        chk("rst_valid", 32'(if_def.pix_valid), 32'd0);
        chk("rst_addr",  32'(if_def.pix_addr),  32'd0);
        chk("rst_data",  32'(if_def.pix_data),  32'd0);
        chk("rst_sat_state", 32'(if_sat.state), 32'd0);

        // Free run: four complete frames plus part of a fifth.
        reset = 1'b0;
        run(2400);
        chk("bursts",       n_bursts, 32'd4);
        chk("valid_cycles", n_valid,  32'd16);

        // 2400 mod 521 = 316: mid-CONVERT. Abort the frame.
        chk("pre_reset_conv", 32'(if_def.state), 32'd3);
        reset = 1'b1;
        tick();
        chk("conv_rst_state", 32'(if_def.state),     32'd0);
        chk("conv_rst_valid", 32'(if_def.pix_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("conv_rst_mem%0d", k),     32'(dut.w_mem[k]),     32'd0);
            chk($sformatf("conv_rst_sat_mem%0d", k), 32'(dut_sat.w_mem[k]), 32'd0);
        end

        // Fresh frame up to READ address 1, then abort during readout.
        reset = 1'b0;
        prev_valid = 1'b0;
        run(518);
        chk("pre_reset_read_addr", 32'(if_def.pix_addr), 32'd1);
        reset = 1'b1;
        tick();
        chk("read_rst_state", 32'(if_def.state),     32'd0);
        chk("read_rst_valid", 32'(if_def.pix_valid), 32'd0);
        chk("read_rst_addr",  32'(if_def.pix_addr),  32'd0);
        chk("read_rst_data",  32'(if_def.pix_data),  32'd0);

        // Two clean frames after the aborted readout.
        reset = 1'b0;
        prev_valid = 1'b0;
        run(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
